tone_gen: RTL and testbench
===========================

# tone_gen

Square-wave tone generator fed by the CPU-written period register. Each clock it compares against that register's `period` output and produces a glitch-free 1-bit audio waveform for the board's audio amplifier. A new period is adopted only at a waveform boundary, so CPU writes never truncate a half-cycle.

## Interface
Parameters:
- `Dbits`, 32, width of `period`, in clock cycles per full waveform cycle.
- `DurBits`, 16, width of `duration` (only with `TONE_GEN_DURATION_EN`).

Ports:
- `clock` in 1: single clock; all state changes on posedge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `period` in Dbits: full-cycle length in clocks, from the period register.
- `enable` in 1: level; permits tone output.
- `audio_out` out 1: registered square wave.
- `audio_en` out 1: registered; high whenever the FSM is not IDLE (amplifier un-mute).
- `cycle_strobe` out 1: one-cycle pulse, coincident with the first high cycle of every waveform cycle.
- `start` in 1 (macro only): one-cycle pulse that loads `duration`.
- `duration` in DurBits (macro only): number of full waveform cycles to play.
- `note_done` out 1 (macro only): one-cycle pulse when the duration is exhausted.

## Operation
- Phase split for latched period P: high = floor(P/2) cycles, low = P − floor(P/2) cycles.
- P < 2 (0 or 1) means silence; never enters HIGH.
- FSM states are IDLE, HIGH and LOW.
- IDLE: `audio_out`=0, `audio_en`=0. If `enable` and `period`≥2 (and duration count ≠ 0 under macro), latch `period` into `cur_period`, load down-counter with high−1, go to HIGH.
- HIGH: `audio_out`=1. When counter = 0, load low−1 and go to LOW.
- LOW: `audio_out`=0. When counter = 0 (end of cycle), re-sample `period` and `enable`:
  - If still valid, latch the new period and go to HIGH.
  - Otherwise go to IDLE.
- Changes to `period` mid-cycle are ignored until the LOW→boundary sample.
- `enable` falling mid-cycle: the current cycle completes, then IDLE.
- Counter width is Dbits; all arithmetic is unsigned and the counter never wraps.

## Timing
- Reset values: state IDLE, `audio_out`=0, `audio_en`=0, `cycle_strobe`=0, `note_done`=0, counters 0, `cur_period` 0.
- Start latency: `enable`/`period` valid at edge N (IDLE) gives `audio_out`=1, `audio_en`=1 and `cycle_strobe`=1 after edge N+1.
- Back-to-back cycles have no gap: the cycle after the last LOW cycle is HIGH.
- Reset asserted mid-note forces all outputs to reset values immediately (asynchronously). Operation resumes from IDLE after `reset_n` deasserts.

## Configuration
- `TONE_GEN_DURATION_EN` defined:
  - Adds `start`, `duration` and `note_done`, plus a DurBits cycle counter.
  - `start` in IDLE loads the counter; `start` outside IDLE is ignored.
  - Each completed waveform cycle decrements the counter.
  - Reaching 0 at a cycle boundary forces IDLE and pulses `note_done` on the same edge as `audio_en` falls.
  - `start` with `duration`=0 pulses `note_done` one cycle later and produces no tone.
- `TONE_GEN_DURATION_EN` not defined: those ports and the counter are absent, and the tone plays continuously while `enable` is high and `period`≥2.

## Structure
- Shared package `tone_gen_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, HIGH, LOW} tone_state_t`
  - `localparam MIN_PERIOD = 2`
- One natural sub-module, `tone_phase_counter`: a loadable Dbits down-counter with a `zero` flag, instantiated once.

## Test plan
- Period 4, enable=1: `audio_out` 1,1,0,0 repeating. `cycle_strobe` every 4th cycle. First high appears 1 cycle after enable.
- Period 5: high 2 cycles, low 3. Period 2: alternates 1,0 every cycle.
- Period 0 and period 1 with enable=1: `audio_out`=0 and `audio_en`=0 indefinitely.
- Period changes 8→4 during the HIGH phase: the current cycle finishes as 4 high and 4 low, and the next cycle is 2/2. Enable dropped during HIGH: the cycle completes, then `audio_en`=0.
- `reset_n` low mid-HIGH: `audio_out` is 0 immediately, with no clock edge required. After release with enable=1, period=6: a 3/3 waveform restarts.
- With macro, period 4, start with duration=3: exactly 12 tone cycles, then `note_done` pulses once and `audio_en` falls. Start with duration=0: `note_done` pulses after 1 cycle and `audio_out` stays 0.

Source files
------------

// File: rtl/tone_gen_pkg.sv
// Shared types and constants for the square-wave tone generator.
package tone_gen_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} tone_state_t;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/tone_gen_phase_counter.sv
// Loadable down-counter timing one phase of the waveform; saturates at zero.
module tone_phase_counter #(
    parameter int Dbits = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [Dbits-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Dbits-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - Dbits'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/tone_gen.sv
// Glitch-free square-wave tone generator; new periods are adopted only at cycle boundaries.
// Optional note-length support is enabled with `define TONE_GEN_DURATION_EN.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int Dbits = 32
`ifdef TONE_GEN_DURATION_EN
    ,
    parameter int DurBits = 16
`endif
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [Dbits-1:0]   period,
    input  logic               enable,
    output logic               audio_out,
    output logic               audio_en,
    output logic               cycle_strobe
`ifdef TONE_GEN_DURATION_EN
    ,
    input  logic               start,
    input  logic [DurBits-1:0] duration,
    output logic               note_done
`endif
);

    tone_state_t      state_q, state_d;
    logic [Dbits-1:0] cur_period_q, cur_period_d;
    logic             audio_out_q, audio_out_d;
    logic             audio_en_q, audio_en_d;
    logic             cycle_strobe_q, cycle_strobe_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [Dbits-1:0] cnt_load_val;
    logic             period_ok;

`ifdef TONE_GEN_DURATION_EN
    logic [DurBits-1:0] dur_q, dur_d;
    logic               note_done_q, note_done_d;
`endif

    // High phase gets the smaller half so odd periods spend the extra clock low.
    function automatic logic [Dbits-1:0] high_len(input logic [Dbits-1:0] p);
        return p >> 1;
    endfunction

    function automatic logic [Dbits-1:0] low_len(input logic [Dbits-1:0] p);
        return p - (p >> 1);
    endfunction

    assign period_ok = enable && (period >= Dbits'(MIN_PERIOD));

    tone_phase_counter #(
        .Dbits(Dbits)
    ) u_phase_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cur_period_q   <= '0;
            audio_out_q    <= 1'b0;
            audio_en_q     <= 1'b0;
            cycle_strobe_q <= 1'b0;
`ifdef TONE_GEN_DURATION_EN
            dur_q          <= '0;
            note_done_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cur_period_q   <= cur_period_d;
            audio_out_q    <= audio_out_d;
            audio_en_q     <= audio_en_d;
            cycle_strobe_q <= cycle_strobe_d;
`ifdef TONE_GEN_DURATION_EN
            dur_q          <= dur_d;
            note_done_q    <= note_done_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_period_d = cur_period_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef TONE_GEN_DURATION_EN
        dur_d        = dur_q;
        note_done_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef TONE_GEN_DURATION_EN
                if (start) begin
                    dur_d       = duration;
                    note_done_d = (duration == '0);
                end
                if (period_ok && (dur_d != '0)) begin
`else
                if (period_ok) begin
`endif
                    state_d      = HIGH;
                    cur_period_d = period;
                    cnt_load     = 1'b1;
                    cnt_load_val = high_len(period) - Dbits'(1);
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    state_d      = LOW;
                    cnt_load     = 1'b1;
                    cnt_load_val = low_len(cur_period_q) - Dbits'(1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    // Cycle boundary: the only point where period/enable are re-sampled.
`ifdef TONE_GEN_DURATION_EN
                    dur_d = dur_q - DurBits'(1);
                    if (period_ok && (dur_d != '0)) begin
`else
                    if (period_ok) begin
`endif
                        state_d      = HIGH;
                        cur_period_d = period;
                        cnt_load     = 1'b1;
                        cnt_load_val = high_len(period) - Dbits'(1);
                    end else begin
                        state_d = IDLE;
`ifdef TONE_GEN_DURATION_EN
                        note_done_d = (dur_d == '0);
`endif
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        audio_out_d    = (state_d == HIGH);
        audio_en_d     = (state_d != IDLE);
        cycle_strobe_d = (state_d == HIGH) && (state_q != HIGH);
    end

    assign audio_out    = audio_out_q;
    assign audio_en     = audio_en_q;
    assign cycle_strobe = cycle_strobe_q;
`ifdef TONE_GEN_DURATION_EN
    assign note_done    = note_done_q;
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Randomised and directed checks of tone_gen against a cycle-position reference model.
module tb_tone_gen;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] period = '0;
    logic        enable = 1'b0;
    logic        audio_out, audio_en, cycle_strobe;
`ifdef TONE_GEN_DURATION_EN
    logic        start = 1'b0;
    logic [15:0] duration = '0;
    logic        note_done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the current waveform cycle.
    bit          m_play = 0;
    int unsigned m_pos = 0;
    int unsigned m_p = 0;
    bit          m_out = 0, m_en = 0, m_strobe = 0, m_done = 0;
    int          m_dur = 0;

    tone_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .period      (period),
        .enable      (enable),
        .audio_out   (audio_out),
        .audio_en    (audio_en),
        .cycle_strobe(cycle_strobe)
`ifdef TONE_GEN_DURATION_EN
        ,
        .start       (start),
        .duration    (duration),
        .note_done   (note_done)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic bit dur_left();
`ifdef TONE_GEN_DURATION_EN
        return m_dur != 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        m_done = 0;
        if (!reset_n) begin
            m_play = 0; m_pos = 0; m_p = 0; m_dur = 0;
        end else if (!m_play) begin
`ifdef TONE_GEN_DURATION_EN
            if (start) begin
                m_dur = int'(duration);
                if (duration == 0) m_done = 1;
            end
`endif
            if (enable && period >= 2 && dur_left()) begin
                m_play = 1; m_p = period; m_pos = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == m_p) begin
`ifdef TONE_GEN_DURATION_EN
                m_dur--;
`endif
                if (enable && period >= 2 && dur_left()) begin
                    m_p = period; m_pos = 0;
                end else begin
                    m_play = 0;
`ifdef TONE_GEN_DURATION_EN
                    if (m_dur == 0) m_done = 1;
`endif
                end
            end
        end
        m_en     = m_play;
        m_out    = m_play && (m_pos < m_p / 2);
        m_strobe = m_play && (m_pos == 0);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
`ifdef TONE_GEN_DURATION_EN
        start = 1'b0;
`endif
    endtask

    task automatic arm();
`ifdef TONE_GEN_DURATION_EN
        start = 1'b1;
        duration = 16'hFFFF;
`endif
    endtask

    task automatic go_idle();
        enable = 1'b0;
        repeat (12) cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if (audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_audio_out: got %b want 0", audio_out); end
        n_checks++;
        if (audio_en !== 1'b0) begin n_fail++; $display("FAIL reset_audio_en: got %b want 0", audio_en); end
        n_checks++;
        if (cycle_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_strobe: got %b want 0", cycle_strobe); end
        reset_n = 1'b1;
        repeat (2) cycle();
        n_checks++;
        if (audio_en !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got en=%b want 0", audio_en); end
    endtask

    task automatic test_period4();
        period = 4; enable = 1'b1; arm();
        for (int k = 0; k < 16; k++) begin
            cycle();
            n_checks++;
            if (audio_out !== ((k % 4) < 2) || cycle_strobe !== ((k % 4) == 0) || audio_en !== 1'b1) begin
                n_fail++;
                $display("FAIL period4 k=%0d: got out/strobe/en %b%b%b want %b%b1", k, audio_out, cycle_strobe,
                         audio_en, (k % 4) < 2, (k % 4) == 0);
            end
        end
        go_idle();
    endtask

    task automatic test_period5_and_2();
        period = 5; enable = 1'b1; arm();
        for (int k = 0; k < 15; k++) begin
            cycle();
            n_checks++;
            if (audio_out !== ((k % 5) < 2) || cycle_strobe !== ((k % 5) == 0)) begin
                n_fail++;
                $display("FAIL period5 k=%0d: got out/strobe %b%b want %b%b", k, audio_out, cycle_strobe,
                         (k % 5) < 2, (k % 5) == 0);
            end
        end
        go_idle();
        period = 2; enable = 1'b1; arm();
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_checks++;
            if (audio_out !== ((k % 2) == 0) || cycle_strobe !== ((k % 2) == 0)) begin
                n_fail++;
                $display("FAIL period2 k=%0d: got out/strobe %b%b want %b", k, audio_out, cycle_strobe, (k % 2) == 0);
            end
        end
        go_idle();
    endtask

    task automatic test_silence();
        for (int p = 0; p < 2; p++) begin
            period = p; enable = 1'b1;
            for (int k = 0; k < 10; k++) begin
                cycle();
                n_checks++;
                if (audio_out !== 1'b0 || audio_en !== 1'b0 || cycle_strobe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL silence_p%0d k=%0d: got out/en/strobe %b%b%b want 000", p, k, audio_out,
                             audio_en, cycle_strobe);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_period_change();
        bit exp;
        period = 8; enable = 1'b1; arm();
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (k == 0) period = 4;
            exp = (k < 8) ? (k < 4) : (((k - 8) % 4) < 2);
            n_checks++;
            if (audio_out !== exp) begin
                n_fail++;
                $display("FAIL period_change k=%0d: got %b want %b", k, audio_out, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        period = 6; enable = 1'b1; arm();
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 1) enable = 1'b0;
            n_checks++;
            if (audio_out !== (k < 3) || audio_en !== (k < 6)) begin
                n_fail++;
                $display("FAIL enable_drop k=%0d: got out/en %b%b want %b%b", k, audio_out, audio_en, k < 3, k < 6);
            end
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        int waited = 0;
        period = 6; enable = 1'b1; arm();
        cycle();
        while (audio_out !== 1'b1 && waited < 20) begin cycle(); waited++; end
        n_checks++;
        if (audio_out !== 1'b1) begin n_fail++; $display("FAIL async_setup: got out=%b want 1 within 20 cycles", audio_out); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (audio_out !== 1'b0 || audio_en !== 1'b0 || cycle_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got out/en/strobe %b%b%b want 000 before any edge", audio_out, audio_en,
                     cycle_strobe);
        end
        repeat (2) cycle();
        reset_n = 1'b1; period = 6; enable = 1'b1; arm();
        for (int k = 0; k < 18; k++) begin
            cycle();
            n_checks++;
            if (audio_out !== ((k % 6) < 3) || cycle_strobe !== ((k % 6) == 0)) begin
                n_fail++;
                $display("FAIL restart_p6 k=%0d: got out/strobe %b%b want %b%b", k, audio_out, cycle_strobe,
                         (k % 6) < 3, (k % 6) == 0);
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        period = 3; enable = 1'b1; arm();
        for (int k = 0; k < 1500; k++) begin
            cycle();
            n_checks++;
            if ({audio_out, audio_en, cycle_strobe} !== {m_out, m_en, m_strobe}) begin
                n_fail++;
                $display("FAIL random k=%0d p=%0d en=%b: got out/en/strobe %b%b%b want %b%b%b", k, period, enable,
                         audio_out, audio_en, cycle_strobe, m_out, m_en, m_strobe);
            end
            if ($urandom_range(0, 5) == 0) period = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) enable = ~enable;
        end
        go_idle();
    endtask

`ifdef TONE_GEN_DURATION_EN
    task automatic test_duration();
        int en_cycles = 0;
        int done_pulses = 0;
        period = 4; enable = 1'b1; start = 1'b1; duration = 3;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (audio_en === 1'b1) en_cycles++;
            if (note_done === 1'b1) done_pulses++;
            n_checks++;
            if ({audio_out, audio_en, note_done} !== {m_out, m_en, m_done}) begin
                n_fail++;
                $display("FAIL duration3 k=%0d: got out/en/done %b%b%b want %b%b%b", k, audio_out, audio_en,
                         note_done, m_out, m_en, m_done);
            end
        end
        n_checks++;
        if (en_cycles != 12) begin n_fail++; $display("FAIL duration3_len: got %0d want 12", en_cycles); end
        n_checks++;
        if (done_pulses != 1) begin n_fail++; $display("FAIL duration3_done: got %0d want 1", done_pulses); end
        start = 1'b1; duration = 0;
        cycle();
        n_checks++;
        if (note_done !== 1'b1 || audio_out !== 1'b0) begin
            n_fail++;
            $display("FAIL duration0: got done/out %b%b want 10", note_done, audio_out);
        end
        cycle();
        n_checks++;
        if (note_done !== 1'b0 || audio_en !== 1'b0) begin
            n_fail++;
            $display("FAIL duration0_after: got done/en %b%b want 00", note_done, audio_en);
        end
        go_idle();
    endtask
`endif

    initial begin
        @(negedge clock);
        test_reset();
        test_period4();
        test_period5_and_2();
        test_silence();
        test_period_change();
        test_enable_drop();
        test_async_reset();
        test_random();
`ifdef TONE_GEN_DURATION_EN
        test_duration();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
